// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch requester, load/store requester
// and the shared memory port. The arbiter uses the slave view; the
// requesters and the memory model together use the master view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Fetch requester
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          if_stall;

  // Load/store requester
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          d_stall;

  // Shared memory port
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport slave (
    input  if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, if_stall, d_rdata, d_ack, d_stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, if_stall, d_rdata, d_ack, d_stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store onto one single-port,
// variable-latency memory. One transaction at a time: IDLE picks a
// requester and latches its command, GNT_x holds the command on the
// memory port until mem_ready, then the result is registered and acked
// for one cycle while the FSM is back in IDLE.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4   // legal range 1..15
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          we_q;
  logic [DW-1:0] if_rdata_q, d_rdata_q;
  logic          if_ack_q, d_ack_q;
  logic [3:0]    starve_cnt;

  logic d_req, if_elig, d_elig, starved;
  logic grant_if, grant_d, done;

  // Arbitration and next-state decode.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    grant_if = 1'b0;
    grant_d  = 1'b0;
    done     = 1'b0;

    d_req   = bus.d_read | bus.d_write;
    if_elig = bus.if_req & ~if_ack_q;
    d_elig  = d_req & ~d_ack_q;
    starved = (starve_cnt == STARVE_LIM);

    case (state_q)
      IDLE: begin
        // A raw data request keeps priority over fetch even in its own ack
        // cycle (where it cannot be re-granted), so back-to-back loads keep
        // the port until the starvation limit hands it to fetch.
        if (if_elig && (!d_req || starved)) begin
          grant_if = 1'b1;
          state_d  = GNT_IF;
        end else if (d_elig) begin
          grant_d = 1'b1;
          state_d = GNT_D;
        end
      end
      GNT_IF, GNT_D: begin
        if (bus.mem_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample the same pre-edge values regardless of block order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Command latch, read-data capture and ack pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
    end else begin
      if_ack_q <= done && (state_q == GNT_IF);
      d_ack_q  <= done && (state_q == GNT_D);

      if (grant_if) begin
        addr_q <= bus.if_addr;
        we_q   <= 1'b0;
      end else if (grant_d) begin
        addr_q  <= bus.d_addr;
        we_q    <= bus.d_write;   // read+write together is a write
        wdata_q <= bus.d_wdata;
      end

      if (done && (state_q == GNT_IF)) if_rdata_q <= bus.mem_rdata;
      if (done && (state_q == GNT_D))  d_rdata_q  <= we_q ? '0 : bus.mem_rdata;
    end
  end

  // Consecutive data grants while fetch waits; saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 starve_cnt <= '0;
    else if (!bus.if_req || grant_if)           starve_cnt <= '0;
    else if (grant_d && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
  end

  assign bus.mem_en    = (state_q != IDLE);
  assign bus.mem_we    = (state_q != IDLE) & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.if_rdata = if_rdata_q;
  assign bus.if_ack   = if_ack_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.d_ack    = d_ack_q;

  assign bus.if_stall = bus.if_req & ~if_ack_q;
  assign bus.d_stall  = (bus.d_read | bus.d_write) & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table for the
// single-transaction cases, then hand-written starvation and
// reset-mid-transaction sequences.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    // stimulus
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    // expected
    logic        e_en;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_if_ack;
    logic [31:0] e_if_rdata;
    logic        e_if_stall;
    logic        e_d_ack;
    logic [31:0] e_d_rdata;
    logic        e_d_stall;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vec [NVEC];

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
    input logic [31:0] da, input logic [31:0] dwd, input logic rdy, input logic [31:0] rd,
    input logic en, input logic we, input logic [31:0] ma, input logic [31:0] mwd,
    input logic ik, input logic [31:0] ird, input logic is,
    input logic dk, input logic [31:0] drd, input logic ds);
    vec_t v;
    v.if_req = ir;  v.if_addr = ia;  v.d_read = dr;  v.d_write = dw;
    v.d_addr = da;  v.d_wdata = dwd; v.mem_ready = rdy; v.mem_rdata = rd;
    v.e_en = en;    v.e_we = we;     v.e_addr = ma;   v.e_wdata = mwd;
    v.e_if_ack = ik; v.e_if_rdata = ird; v.e_if_stall = is;
    v.e_d_ack = dk;  v.e_d_rdata = drd;  v.e_d_stall = ds;
    return v;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.if_req    = v.if_req;
    bus.if_addr   = v.if_addr;
    bus.d_read    = v.d_read;
    bus.d_write   = v.d_write;
    bus.d_addr    = v.d_addr;
    bus.d_wdata   = v.d_wdata;
    bus.mem_ready = v.mem_ready;
    bus.mem_rdata = v.mem_rdata;
  endtask

  task automatic clear_inputs();
    bus.if_req = 1'b0; bus.if_addr = '0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    bus.d_addr = '0;   bus.d_wdata = '0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check1 ({tag, " mem_en"},    bus.mem_en,    1'b0);
    check1 ({tag, " mem_we"},    bus.mem_we,    1'b0);
    check1 ({tag, " if_ack"},    bus.if_ack,    1'b0);
    check1 ({tag, " d_ack"},     bus.d_ack,     1'b0);
    check32({tag, " mem_addr"},  bus.mem_addr,  32'h0);
    check32({tag, " mem_wdata"}, bus.mem_wdata, 32'h0);
    check32({tag, " if_rdata"},  bus.if_rdata,  32'h0);
    check32({tag, " d_rdata"},   bus.d_rdata,   32'h0);
  endtask

  // Watchdog: the whole run is a few hundred cycles.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  ndata;
    bit  fetch_seen;
    int  ack_at;

    // Columns: if_req if_addr d_read d_write d_addr d_wdata rdy rdata |
    //          en we mem_addr mem_wdata if_ack if_rdata if_stall d_ack d_rdata d_stall
    // single fetch
    vec[0]  = mk(1,32'h40, 0,0,32'h0,32'h0, 0,32'h0,      0,0,32'h0,32'h0, 0,32'h0,1,        0,32'h0,0);
    vec[1]  = mk(1,32'h40, 0,0,32'h0,32'h0, 1,32'hDEADBEEF, 1,0,32'h40,32'h0, 0,32'h0,1,     0,32'h0,0);
    vec[2]  = mk(1,32'h40, 0,0,32'h0,32'h0, 0,32'h0,      0,0,32'h0,32'h0, 1,32'hDEADBEEF,0, 0,32'h0,0);
    vec[3]  = mk(0,32'h0,  0,0,32'h0,32'h0, 0,32'h0,      0,0,32'h0,32'h0, 0,32'hDEADBEEF,0, 0,32'h0,0);
    // simultaneous fetch + load: data first, fetch after d_ack, no duplicate
    vec[4]  = mk(1,32'h80, 1,0,32'h200,32'h0, 0,32'h0,      0,0,32'h0,32'h0,   0,32'hDEADBEEF,1, 0,32'h0,1);
    vec[5]  = mk(1,32'h80, 1,0,32'h200,32'h0, 1,32'h11112222, 1,0,32'h200,32'h0, 0,32'hDEADBEEF,1, 0,32'h0,1);
    vec[6]  = mk(1,32'h80, 0,0,32'h0,32'h0,   0,32'h0,      0,0,32'h0,32'h0,   0,32'hDEADBEEF,1, 1,32'h11112222,0);
    vec[7]  = mk(1,32'h80, 0,0,32'h0,32'h0,   1,32'h33334444, 1,0,32'h80,32'h0,  0,32'hDEADBEEF,1, 0,32'h11112222,0);
    vec[8]  = mk(1,32'h80, 0,0,32'h0,32'h0,   0,32'h0,      0,0,32'h0,32'h0,   1,32'h33334444,0, 0,32'h11112222,0);
    vec[9]  = mk(0,32'h0,  0,0,32'h0,32'h0,   1,32'h99999999, 0,0,32'h0,32'h0,   0,32'h33334444,0, 0,32'h11112222,0);
    // write with three wait states
    vec[10] = mk(0,32'h0, 0,1,32'h100,32'h12345678, 0,32'h0,      0,0,32'h0,32'h0,            0,32'h33334444,0, 0,32'h11112222,1);
    vec[11] = mk(0,32'h0, 0,1,32'h100,32'h12345678, 0,32'h0,      1,1,32'h100,32'h12345678,   0,32'h33334444,0, 0,32'h11112222,1);
    vec[12] = mk(0,32'h0, 0,1,32'h100,32'h12345678, 0,32'h0,      1,1,32'h100,32'h12345678,   0,32'h33334444,0, 0,32'h11112222,1);
    vec[13] = mk(0,32'h0, 0,1,32'h100,32'h12345678, 0,32'h0,      1,1,32'h100,32'h12345678,   0,32'h33334444,0, 0,32'h11112222,1);
    vec[14] = mk(0,32'h0, 0,1,32'h100,32'h12345678, 1,32'hAAAAAAAA, 1,1,32'h100,32'h12345678, 0,32'h33334444,0, 0,32'h11112222,1);
    vec[15] = mk(0,32'h0, 0,0,32'h0,32'h0,          0,32'h0,      0,0,32'h0,32'h0,            0,32'h33334444,0, 1,32'h0,0);
    // read+write together: one write, one ack, no re-grant while held
    vec[16] = mk(0,32'h0, 1,1,32'h300,32'hCAFEF00D, 0,32'h0,      0,0,32'h0,32'h0,            0,32'h33334444,0, 0,32'h0,1);
    vec[17] = mk(0,32'h0, 1,1,32'h300,32'hCAFEF00D, 1,32'h55555555, 1,1,32'h300,32'hCAFEF00D, 0,32'h33334444,0, 0,32'h0,1);
    vec[18] = mk(0,32'h0, 1,1,32'h300,32'hCAFEF00D, 0,32'h0,      0,0,32'h0,32'h0,            0,32'h33334444,0, 1,32'h0,0);
    vec[19] = mk(0,32'h0, 0,0,32'h0,32'h0,          1,32'h0,      0,0,32'h0,32'h0,            0,32'h33334444,0, 0,32'h0,0);
    vec[20] = mk(0,32'h0, 0,0,32'h0,32'h0,          0,32'h0,      0,0,32'h0,32'h0,            0,32'h33334444,0, 0,32'h0,0);

    // Reset
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    #1 check_reset_state("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_reset_state("after_reset");
    check1("after_reset starve_cnt_zero", dut.starve_cnt == 4'd0, 1'b1);

    // Table-driven cycles
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vec[i]);
      #1;
      check1($sformatf("v%0d mem_en", i), bus.mem_en, vec[i].e_en);
      check1($sformatf("v%0d mem_we", i), bus.mem_we, vec[i].e_we);
      if (vec[i].e_en)
        check32($sformatf("v%0d mem_addr", i), bus.mem_addr, vec[i].e_addr);
      if (vec[i].e_we)
        check32($sformatf("v%0d mem_wdata", i), bus.mem_wdata, vec[i].e_wdata);
      check1 ($sformatf("v%0d if_ack", i),   bus.if_ack,   vec[i].e_if_ack);
      check32($sformatf("v%0d if_rdata", i), bus.if_rdata, vec[i].e_if_rdata);
      check1 ($sformatf("v%0d if_stall", i), bus.if_stall, vec[i].e_if_stall);
      check1 ($sformatf("v%0d d_ack", i),    bus.d_ack,    vec[i].e_d_ack);
      check32($sformatf("v%0d d_rdata", i),  bus.d_rdata,  vec[i].e_d_rdata);
      check1 ($sformatf("v%0d d_stall", i),  bus.d_stall,  vec[i].e_d_stall);
    end

    // Starvation: load and fetch both held, memory always ready.
    // Expect exactly four data grants, then the fetch grant.
    ndata      = 0;
    fetch_seen = 1'b0;
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 32'h400;
    bus.d_read = 1'b1; bus.d_addr  = 32'h500;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hF00DF00D;
    for (int c = 0; c < 60 && !fetch_seen; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (bus.mem_en && bus.mem_addr == 32'h500) ndata++;
      if (bus.mem_en && bus.mem_addr == 32'h400) begin
        fetch_seen = 1'b1;
        check1("starve starve_cnt_cleared", dut.starve_cnt == 4'd0, 1'b1);
      end
    end
    check1 ("starve fetch_granted", fetch_seen, 1'b1);
    check32("starve data_grants", 32'(ndata), 32'd4);
    // Both requests dropped before the fetch ack: the ack still pulses.
    @(negedge clk);
    clear_inputs();
    #1;
    check1 ("drop if_ack", bus.if_ack, 1'b1);
    check32("drop if_rdata", bus.if_rdata, 32'hF00DF00D);
    check1 ("drop mem_en", bus.mem_en, 1'b0);

    // Reset during GNT_D, then the held load completes normally.
    @(negedge clk);
    bus.d_read = 1'b1; bus.d_addr = 32'h600;
    #1 check1("rst_mid d_stall_idle", bus.d_stall, 1'b1);
    @(negedge clk);
    #1 check1("rst_mid mem_en_gnt", bus.mem_en, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check1("rst_mid mem_en", bus.mem_en, 1'b0);
    check1("rst_mid mem_we", bus.mem_we, 1'b0);
    check1("rst_mid d_ack",  bus.d_ack,  1'b0);
    check1("rst_mid if_ack", bus.if_ack, 1'b0);
    check1("rst_mid d_stall", bus.d_stall, 1'b1);
    @(negedge clk);
    #1 check1("rst_mid no_ack_under_reset", bus.d_ack, 1'b0);
    rst_n = 1'b1;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h77778888;
    ack_at = -1;
    for (int c = 0; c < 10 && ack_at < 0; c++) begin
      @(negedge clk);
      #1;
      if (bus.mem_en) check32($sformatf("rst_mid mem_addr c%0d", c), bus.mem_addr, 32'h600);
      if (bus.d_ack) ack_at = c;
    end
    check32("rst_mid ack_latency", 32'(ack_at), 32'd1);
    check32("rst_mid d_rdata", bus.d_rdata, 32'h77778888);
    @(negedge clk);
    clear_inputs();
    #1;
    check1("rst_mid ack_single", bus.d_ack, 1'b0);
    check1("rst_mid idle", bus.mem_en, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
